// File: rtl/ysyx_22041071_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// ALU_ctrl codes 19..30, FSM state encoding and a small op decoder.
package ysyx_22041071_mdu_pkg;

  localparam logic [4:0] ALU_MUL   = 5'd19;
  localparam logic [4:0] ALU_MULH  = 5'd20;
  localparam logic [4:0] ALU_MULHU = 5'd21;
  localparam logic [4:0] ALU_MULW  = 5'd22;
  localparam logic [4:0] ALU_DIV   = 5'd23;
  localparam logic [4:0] ALU_DIVU  = 5'd24;
  localparam logic [4:0] ALU_DIVW  = 5'd25;
  localparam logic [4:0] ALU_DIVUW = 5'd26;
  localparam logic [4:0] ALU_REM   = 5'd27;
  localparam logic [4:0] ALU_REMU  = 5'd28;
  localparam logic [4:0] ALU_REMUW = 5'd29;
  localparam logic [4:0] ALU_REMW  = 5'd30;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL_REQ  = 3'd1,
    ST_MUL_WAIT = 3'd2,
    ST_DIV_REQ  = 3'd3,
    ST_DIV_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } mdu_state_e;

  typedef struct packed {
    logic is_div;   // divider path (else multiplier)
    logic is_rem;   // take remainder instead of quotient
    logic is_hi;    // take high product half
    logic is_word;  // 32-bit op, result sign-extended from bit 31
    logic sgn_a;
    logic sgn_b;
  } mdu_op_t;

  function automatic logic op_legal(input logic [4:0] ctrl);
    return (ctrl >= ALU_MUL) && (ctrl <= ALU_REMW);
  endfunction

  function automatic mdu_op_t op_decode(input logic [4:0] ctrl);
    mdu_op_t op;
    op = '0;
    case (ctrl)
      ALU_MUL:   begin op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_MULH:  begin op.is_hi = 1'b1; op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_MULHU: begin op.is_hi = 1'b1; end
      ALU_MULW:  begin op.is_word = 1'b1; op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_DIV:   begin op.is_div = 1'b1; op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_DIVU:  begin op.is_div = 1'b1; end
      ALU_DIVW:  begin op.is_div = 1'b1; op.is_word = 1'b1; op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_DIVUW: begin op.is_div = 1'b1; op.is_word = 1'b1; end
      ALU_REM:   begin op.is_div = 1'b1; op.is_rem = 1'b1; op.sgn_a = 1'b1; op.sgn_b = 1'b1; end
      ALU_REMU:  begin op.is_div = 1'b1; op.is_rem = 1'b1; end
      ALU_REMUW: begin op.is_div = 1'b1; op.is_rem = 1'b1; op.is_word = 1'b1; end
      ALU_REMW:  begin
        op.is_div = 1'b1; op.is_rem = 1'b1; op.is_word = 1'b1;
        op.sgn_a = 1'b1; op.sgn_b = 1'b1;
      end
      default:   op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_22041071_mdu_fmt.sv
// Combinational op decode and result formatting for the mdu sequencer.
// Ports:
//   dec_ctrl/src1/src2  incoming op (decode side)
//   dec_op/dec_legal    decoded op fields, code in 19..30
//   opnd_a/opnd_b       operands as sent to the units (word divides pre-extended)
//   special/special_result  divide-by-zero or signed overflow, resolved locally
//   res_op + unit outputs   op in flight and raw unit results
//   unit_result         selected and word-formatted unit result
module ysyx_22041071_mdu_fmt
  import ysyx_22041071_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [4:0]      dec_ctrl,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output mdu_op_t         dec_op,
  output logic            dec_legal,
  output logic [XLEN-1:0] opnd_a,
  output logic [XLEN-1:0] opnd_b,
  output logic            special,
  output logic [XLEN-1:0] special_result,
  input  mdu_op_t         res_op,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  input  logic [XLEN-1:0] div_q,
  input  logic [XLEN-1:0] div_r,
  output logic [XLEN-1:0] unit_result
);

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  logic            div_by_zero;
  logic            overflow;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] special_raw;
  logic [XLEN-1:0] unit_sel;

  always_comb begin
    dec_op    = op_decode(dec_ctrl);
    dec_legal = op_legal(dec_ctrl);
    opnd_a    = src1;
    opnd_b    = src2;
    // Word divides see only the low 32 bits; extending them here lets the
    // special-case compare and the divider both work at full XLEN.
    if (dec_op.is_div && dec_op.is_word) begin
      opnd_a = dec_op.sgn_a ? sext_w(src1) : zext_w(src1);
      opnd_b = dec_op.sgn_b ? sext_w(src2) : zext_w(src2);
    end
  end

  always_comb begin
    min_val     = dec_op.is_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                                 : {1'b1, {(XLEN-1){1'b0}}};
    div_by_zero = (opnd_b == '0);
    overflow    = dec_op.sgn_a && (opnd_a == min_val) && (opnd_b == '1);
    special     = dec_legal && dec_op.is_div && (div_by_zero || overflow);
    if (div_by_zero) begin
      special_raw = dec_op.is_rem ? opnd_a : '1;
    end else begin
      special_raw = dec_op.is_rem ? '0 : opnd_a;
    end
    special_result = dec_op.is_word ? sext_w(special_raw) : special_raw;
  end

  always_comb begin
    if (res_op.is_div) begin
      unit_sel = res_op.is_rem ? div_r : div_q;
    end else begin
      unit_sel = res_op.is_hi ? mul_hi : mul_lo;
    end
    unit_result = res_op.is_word ? sext_w(unit_sel) : unit_sel;
  end

endmodule

// File: rtl/ysyx_22041071_mdu_ctrl.sv
// EX-stage multiply/divide sequencer. Accepts one op at a time, issues it to
// the shared iterative multiplier or divider (or resolves divide special cases
// locally), and returns one formatted result to WB over valid/ready.
// Ports: in_* op from ID/EX; out_* result to WB; stall to hazard logic;
//   mul_*/div_* unit issue and completion; unit_flush abort pulse;
//   busy_cnt saturating count of stalled cycles.
//
// state    | meaning
// IDLE     | ready for a new op
// MUL_REQ  | presenting op to multiplier, waiting for mul_ready
// MUL_WAIT | multiplier running, waiting for mul_done
// DIV_REQ  | presenting op to divider, waiting for div_ready
// DIV_WAIT | divider running, waiting for div_done
// DONE     | result held on out_result until out_ready
module ysyx_22041071_mdu_ctrl
  import ysyx_22041071_mdu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_ctrl,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              stall,
  output logic              mul_valid,
  input  logic              mul_ready,
  output logic [1:0]        mul_signed,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [XLEN-1:0]   mul_hi,
  input  logic [XLEN-1:0]   mul_lo,
  output logic              div_valid,
  input  logic              div_ready,
  output logic              div_signed,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic              div_done,
  input  logic [XLEN-1:0]   div_q,
  input  logic [XLEN-1:0]   div_r,
  output logic              unit_flush,
  output logic [PCNT_W-1:0] busy_cnt
);

  mdu_state_e        state_q, state_d;
  mdu_op_t           op_q;
  logic [XLEN-1:0]   opa_q, opb_q, result_q;
  logic              unit_flush_q;
  logic [PCNT_W-1:0] busy_cnt_q;

  mdu_op_t           dec_op;
  logic              dec_legal;
  logic [XLEN-1:0]   opnd_a, opnd_b, special_result, unit_result;
  logic              special;

  logic              load_op;
  logic              take_result;
  logic              flush_units;

  ysyx_22041071_mdu_fmt #(.XLEN(XLEN)) u_fmt (
    .dec_ctrl       (in_ctrl),
    .src1           (in_src1),
    .src2           (in_src2),
    .dec_op         (dec_op),
    .dec_legal      (dec_legal),
    .opnd_a         (opnd_a),
    .opnd_b         (opnd_b),
    .special        (special),
    .special_result (special_result),
    .res_op         (op_q),
    .mul_hi         (mul_hi),
    .mul_lo         (mul_lo),
    .div_q          (div_q),
    .div_r          (div_r),
    .unit_result    (unit_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_op     = 1'b0;
    take_result = 1'b0;
    flush_units = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    mul_valid   = 1'b0;
    div_valid   = 1'b0;
    stall       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        // Illegal codes and ops arriving with a flush are simply not taken.
        if (in_valid && dec_legal && !flush) begin
          load_op = 1'b1;
          if (special)            state_d = ST_DONE;
          else if (dec_op.is_div) state_d = ST_DIV_REQ;
          else                    state_d = ST_MUL_REQ;
        end
      end
      ST_MUL_REQ: begin
        mul_valid = 1'b1;
        if (flush) begin
          state_d     = ST_IDLE;
          flush_units = mul_ready;
        end else if (mul_ready) begin
          state_d = ST_MUL_WAIT;
        end
      end
      ST_MUL_WAIT: begin
        if (flush) begin
          state_d     = ST_IDLE;
          flush_units = 1'b1;
        end else if (mul_done) begin
          take_result = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DIV_REQ: begin
        div_valid = 1'b1;
        if (flush) begin
          state_d     = ST_IDLE;
          flush_units = div_ready;
        end else if (div_ready) begin
          state_d = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (flush) begin
          state_d     = ST_IDLE;
          flush_units = 1'b1;
        end else if (div_done) begin
          take_result = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      unit_flush_q <= 1'b0;
      busy_cnt_q   <= '0;
    end else begin
      unit_flush_q <= flush_units;
      if (load_op) begin
        op_q  <= dec_op;
        opa_q <= opnd_a;
        opb_q <= opnd_b;
        if (special) result_q <= special_result;
      end
      if (take_result) result_q <= unit_result;
      if (stall && (busy_cnt_q != '1)) busy_cnt_q <= busy_cnt_q + PCNT_W'(1);
    end
  end

  assign out_result = result_q;
  assign mul_signed = {op_q.sgn_a, op_q.sgn_b};
  assign mul_a      = opa_q;
  assign mul_b      = opb_q;
  assign div_signed = op_q.sgn_a;
  assign div_a      = opa_q;
  assign div_b      = opb_q;
  assign unit_flush = unit_flush_q;
  assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_ysyx_22041071_mdu_ctrl.sv
// Bench for the mdu sequencer: behavioural multiplier/divider models answer
// the unit handshakes, a vector table drives ops, expected results go through
// a scoreboard queue popped when WB accepts a result.
module tb_ysyx_22041071_mdu_ctrl;

  logic        clk, reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready, stall;
  logic [4:0]  in_ctrl;
  logic [63:0] in_src1, in_src2, out_result;
  logic        mul_valid, mul_ready, mul_done;
  logic [1:0]  mul_signed;
  logic [63:0] mul_a, mul_b, mul_hi, mul_lo;
  logic        div_valid, div_ready, div_done, div_signed;
  logic [63:0] div_a, div_b, div_q, div_r;
  logic        unit_flush;
  logic [15:0] busy_cnt;

  ysyx_22041071_mdu_ctrl #(.XLEN(64), .PCNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .stall(stall),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_signed(mul_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .unit_flush(unit_flush), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [63:0] src1;
    logic [63:0] src2;
    int          lat;
    int          hold;
    bit          issue;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];

  // unit models; manual mode lets a sequence place handshakes precisely
  bit          mock_en = 1'b1;
  int          mul_lat = 1, div_lat = 1;
  logic        man_mul_ready = 0, man_mul_done = 0, man_div_ready = 0, man_div_done = 0;
  logic [63:0] man_mul_lo = 0, man_div_q = 0, man_div_r = 0;

  initial begin
    int          m_cnt, d_cnt;
    bit          m_hs, d_hs;
    logic [63:0] m_a, m_b, d_a, d_b;
    logic [1:0]  m_s;
    logic        d_s;
    logic [127:0] prod;
    m_cnt = 0; d_cnt = 0; m_a = 0; m_b = 0; d_a = 0; d_b = 0; m_s = 0; d_s = 0;
    mul_ready = 0; mul_done = 0; mul_hi = 0; mul_lo = 0;
    div_ready = 0; div_done = 0; div_q = 0; div_r = 0;
    forever begin
      @(negedge clk);
      m_hs = mul_valid && mul_ready;
      d_hs = div_valid && div_ready;
      if (m_hs) begin m_a = mul_a; m_b = mul_b; m_s = mul_signed; end
      if (d_hs) begin d_a = div_a; d_b = div_b; d_s = div_signed; end
      @(posedge clk);
      #2;
      mul_done = 0;
      div_done = 0;
      if (!reset) begin m_cnt = 0; d_cnt = 0; end
      if (mock_en) begin
        mul_ready = 1;
        div_ready = 1;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (m_s == 2'b11)
              prod = 128'($signed({{64{m_a[63]}}, m_a}) * $signed({{64{m_b[63]}}, m_b}));
            else
              prod = {64'd0, m_a} * {64'd0, m_b};
            mul_hi = prod[127:64];
            mul_lo = prod[63:0];
            mul_done = 1;
          end
        end
        if (d_cnt > 0) begin
          d_cnt--;
          if (d_cnt == 0) begin
            if (d_b == 0) begin
              div_q = '1; div_r = d_a;
            end else if (d_s && d_a == 64'h8000_0000_0000_0000 && d_b == '1) begin
              div_q = d_a; div_r = 0;
            end else if (d_s) begin
              div_q = $signed(d_a) / $signed(d_b);
              div_r = $signed(d_a) % $signed(d_b);
            end else begin
              div_q = d_a / d_b;
              div_r = d_a % d_b;
            end
            div_done = 1;
          end
        end
        if (m_hs) m_cnt = mul_lat;
        if (d_hs) d_cnt = div_lat;
      end else begin
        m_cnt = 0; d_cnt = 0;
        mul_ready = man_mul_ready; mul_done = man_mul_done; mul_lo = man_mul_lo;
        div_ready = man_div_ready; div_done = man_div_done;
        div_q = man_div_q; div_r = man_div_r;
      end
    end
  end

  // scoreboard: pop on every WB handshake
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h with no pending result", out_result);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("result[v%0d]", e.idx), out_result, e.exp);
        end
      end
    end
  end

  // expected busy count: each clock edge counts the stall level seen before it
  int bc_exp = 0;
  bit st_prev = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) bc_exp = 0;
      else if (st_prev) bc_exp++;
      st_prev = reset && stall;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // called at posedge+1, returns at posedge+1
  task automatic run_op(input vec_t v, input int idx);
    int cyc;
    int stall_n;
    bit issued;
    mul_lat = v.lat;
    div_lat = v.lat;
    out_ready = (v.hold == 0);
    in_ctrl = v.ctrl; in_src1 = v.src1; in_src2 = v.src2; in_valid = 1;
    @(negedge clk);
    check($sformatf("accept[v%0d]", idx), in_ready, 1);
    sb_q.push_back('{idx, v.exp});
    @(posedge clk); #1;
    in_valid = 0;
    cyc = 0; stall_n = 0; issued = 0;
    do begin
      @(negedge clk);
      if (mul_valid || div_valid) issued = 1;
      if (stall) stall_n++;
      cyc++;
    end while (!out_valid && cyc < 200);
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout[v%0d]: got no out_valid expected out_valid within 200 cycles", idx);
      sb_q.delete();
      @(posedge clk); #1;
      return;
    end
    check($sformatf("issue[v%0d]", idx), issued, v.issue);
    if (!v.issue) check($sformatf("special_lat[v%0d]", idx), cyc, 1);
    else check($sformatf("stall_len[v%0d]", idx), stall_n >= v.lat, 1);
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        check($sformatf("hold_valid[v%0d]", idx), out_valid, 1);
        check($sformatf("hold_result[v%0d]", idx), out_result, v.exp);
        @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    check($sformatf("idle_after[v%0d]", idx), {in_ready, out_valid, stall}, 3'b100);
    @(negedge clk); #1;
    check($sformatf("busy_cnt[v%0d]", idx), 64'(busy_cnt), 64'(bc_exp));
    @(posedge clk); #1;
  endtask

  task automatic flush_in_mul_req(input logic rdy, input logic exp_uf);
    mock_en = 0; man_mul_ready = rdy;
    in_ctrl = 5'd19; in_src1 = 64'd6; in_src2 = 64'd7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("req_mul_valid", mul_valid, 1);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("req_flush_uf", unit_flush, exp_uf);
    check("req_flush_idle", {in_ready, mul_valid, out_valid}, 3'b100);
    @(posedge clk); #1;
    man_mul_ready = 0; mock_en = 1;
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{5'd19, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 4, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
    vecs[1]  = '{5'd20, 64'h8000_0000_0000_0000, 64'd2, 2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3]  = '{5'd22, 64'h1234_0000_7FFF_FFFF, 64'd2, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[4]  = '{5'd25, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0, 64'hFFFF_FFFF_8000_0000};
    vecs[5]  = '{5'd28, 64'd17, 64'd0, 1, 0, 1'b0, 64'd17};
    vecs[6]  = '{5'd24, 64'd17, 64'd0, 1, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{5'd23, 64'd100, 64'd7, 3, 3, 1'b1, 64'd14};
    vecs[8]  = '{5'd27, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9]  = '{5'd26, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 2, 0, 1'b1, 64'h0000_0000_0FFF_FFFF};
    vecs[10] = '{5'd29, 64'h0000_0001_0000_0005, 64'h0000_0001_0000_0000, 1, 0, 1'b0, 64'd5};
    vecs[11] = '{5'd30, 64'h0000_0000_FFFF_FFF9, 64'd2, 2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{5'd23, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0, 64'h8000_0000_0000_0000};
    vecs[13] = '{5'd27, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0, 64'd0};
    vecs[14] = '{5'd25, 64'd5, 64'hFFFF_FFFF_0000_0000, 1, 2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};

    reset = 0; in_valid = 0; in_ctrl = 0; in_src1 = 0; in_src2 = 0;
    flush = 0; out_ready = 1;
    #2;
    check("rst_outputs", {in_ready, out_valid, stall, mul_valid, div_valid, unit_flush}, 6'b100000);
    check("rst_result", out_result, 0);
    check("rst_busy", 64'(busy_cnt), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_op(vecs[i], i);

    // illegal code held valid: never taken, in_ready stays up
    in_ctrl = 5'd5; in_src1 = 64'd1; in_src2 = 64'd1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("illegal_ready", {in_ready, stall}, 2'b10);
      @(posedge clk); #1;
    end
    // legal op together with flush in IDLE: not taken
    in_ctrl = 5'd19; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    @(negedge clk);
    check("flush_idle_noacc", {in_ready, stall, mul_valid}, 3'b100);
    @(posedge clk); #1;

    // stray mul_done in IDLE is ignored
    mock_en = 0; man_mul_done = 1; man_mul_lo = 64'h55;
    @(posedge clk); #1;
    man_mul_done = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("stray_done", {out_valid, stall}, 2'b00);
    @(posedge clk); #1;

    // flush in DIV_WAIT together with div_done: flush wins
    man_div_ready = 1;
    in_ctrl = 5'd23; in_src1 = 64'd100; in_src2 = 64'd7; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check("fdw_div_valid", div_valid, 1);
    @(posedge clk); #1;
    man_div_ready = 0; man_div_done = 1; man_div_q = 64'd14; man_div_r = 64'd2; flush = 1;
    @(negedge clk);
    check("fdw_in_wait", {stall, div_valid}, 2'b10);
    @(posedge clk); #1;
    flush = 0; man_div_done = 0;
    @(negedge clk);
    check("fdw_unit_flush", unit_flush, 1);
    check("fdw_state", {in_ready, out_valid, stall}, 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    check("fdw_uf_pulse", {unit_flush, out_valid}, 2'b00);
    @(posedge clk); #1;
    mock_en = 1;
    @(posedge clk); #1;

    flush_in_mul_req(1'b0, 1'b0);
    flush_in_mul_req(1'b1, 1'b1);

    // async reset in MUL_WAIT
    mul_lat = 20; out_ready = 1;
    in_ctrl = 5'd19; in_src1 = 64'd3; in_src2 = 64'd5; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", {stall, in_ready, mul_valid}, 3'b100);
    #2 reset = 0;
    #1;
    check("mid_rst_outputs", {in_ready, out_valid, stall, mul_valid, div_valid, unit_flush}, 6'b100000);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_busy", 64'(busy_cnt), 0);
    check("mid_rst_opnd", mul_a, 0);
    @(negedge clk);
    #1 reset = 1;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) check("post_rst_spurious", out_valid, 0);
    end
    @(posedge clk); #1;
    run_op(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
